// File: rtl/serial_adder_if.sv
//------------------------------------------------------------------------------
// Module  : serial_adder_if
// Brief   : Handshake and operand/result bundle for the bit-serial adder.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

`default_nettype wire

// File: rtl/serial_adder.sv
//------------------------------------------------------------------------------
// Module  : serial_adder
// Brief   : Bit-serial LSB-first adder: one full-adder slice plus a carry flop.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    serial_adder_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] psum;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    logic             bit_s;
    logic             carry_next;
    logic [WIDTH-1:0] psum_next;

    assign bit_s      = a_sr[0] ^ b_sr[0] ^ carry;
    assign carry_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    // New bit enters at the MSB; the cast keeps this legal for WIDTH == 1.
    assign psum_next  = WIDTH'({bit_s, psum} >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr  <= bus.a;
                        b_sr  <= bus.b;
                        carry <= bus.cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    psum  <= psum_next;
                    carry <= carry_next;
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        sum   <= psum_next;
                        cout  <= carry_next;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.sum  = sum;
    assign bus.cout = cout;
endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
//------------------------------------------------------------------------------
// Module  : tb_serial_adder
// Brief   : Scoreboard bench for serial_adder at WIDTH = 8, 1 and 16.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder_if #(.WIDTH(8))  if8();
    serial_adder_if #(.WIDTH(1))  if1();
    serial_adder_if #(.WIDTH(16)) if16();

    serial_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    serial_adder #(.WIDTH(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        int          done_cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q1[$];
    exp_t q16[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_result(input string tag, input exp_t e, input logic [15:0] s,
                                input logic c, input int run, input int width);
        chk({tag, " sum"},     32'(s), 32'(e.sum));
        chk({tag, " cout"},    32'(c), 32'(e.cout));
        chk({tag, " latency"}, 32'(cyc), 32'(e.done_cyc));
        chk({tag, " busy len"}, 32'(run), 32'(width));
    endtask

    // Monitors: pop an expectation on every done pulse, otherwise the result must hold.
    int          run8 = 0, run1 = 0, run16 = 0;
    logic [15:0] hs8 = '0, hs1 = '0, hs16 = '0;
    logic        hc8 = 1'b0, hc1 = 1'b0, hc16 = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            q8.delete(); run8 = 0; hs8 = '0; hc8 = 1'b0;
        end else if (if8.done) begin
            chk("w8 done expected", 32'(q8.size() != 0), 32'd1);
            if (q8.size() != 0) check_result("w8", q8.pop_front(), 16'(if8.sum), if8.cout, run8, 8);
            hs8 = 16'(if8.sum); hc8 = if8.cout; run8 = 0;
        end else begin
            chk("w8 result hold", {15'd0, if8.cout, 16'(if8.sum)}, {15'd0, hc8, hs8});
            if (if8.busy) run8++;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q1.delete(); run1 = 0; hs1 = '0; hc1 = 1'b0;
        end else if (if1.done) begin
            chk("w1 done expected", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) check_result("w1", q1.pop_front(), 16'(if1.sum), if1.cout, run1, 1);
            hs1 = 16'(if1.sum); hc1 = if1.cout; run1 = 0;
        end else begin
            chk("w1 result hold", {15'd0, if1.cout, 16'(if1.sum)}, {15'd0, hc1, hs1});
            if (if1.busy) run1++;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q16.delete(); run16 = 0; hs16 = '0; hc16 = 1'b0;
        end else if (if16.done) begin
            chk("w16 done expected", 32'(q16.size() != 0), 32'd1);
            if (q16.size() != 0) check_result("w16", q16.pop_front(), if16.sum, if16.cout, run16, 16);
            hs16 = if16.sum; hc16 = if16.cout; run16 = 0;
        end else begin
            chk("w16 result hold", {15'd0, if16.cout, if16.sum}, {15'd0, hc16, hs16});
            if (if16.busy) run16++;
        end
    end

    // Drivers: wait until the block is in IDLE, present one start pulse and log the expectation.
    task automatic wait_idle8();
        int i;
        @(negedge clk);
        for (i = 0; i < 50 && (if8.busy || if8.done); i++) @(negedge clk);
        if (if8.busy || if8.done) chk("w8 idle timeout", 32'd1, 32'd0);
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic [7:0] es, input logic ec);
        wait_idle8();
        if8.start = 1'b1; if8.a = a; if8.b = b; if8.cin = cin;
        q8.push_back('{sum: 16'(es), cout: ec, done_cyc: cyc + 1 + 8});
        @(negedge clk);
        if8.start = 1'b0;
    endtask

    task automatic issue1(input logic a, input logic b, input logic cin,
                          input logic es, input logic ec);
        int i;
        @(negedge clk);
        for (i = 0; i < 50 && (if1.busy || if1.done); i++) @(negedge clk);
        if (if1.busy || if1.done) chk("w1 idle timeout", 32'd1, 32'd0);
        if1.start = 1'b1; if1.a = a; if1.b = b; if1.cin = cin;
        q1.push_back('{sum: 16'(es), cout: ec, done_cyc: cyc + 1 + 1});
        @(negedge clk);
        if1.start = 1'b0;
    endtask

    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                           input logic [15:0] es, input logic ec);
        int i;
        @(negedge clk);
        for (i = 0; i < 50 && (if16.busy || if16.done); i++) @(negedge clk);
        if (if16.busy || if16.done) chk("w16 idle timeout", 32'd1, 32'd0);
        if16.start = 1'b1; if16.a = a; if16.b = b; if16.cin = cin;
        q16.push_back('{sum: es, cout: ec, done_cyc: cyc + 1 + 16});
        @(negedge clk);
        if16.start = 1'b0;
    endtask

    initial begin
        int base;
        int ndone;
        if8.start = 1'b0;  if8.a = '0;  if8.b = '0;  if8.cin = 1'b0;
        if1.start = 1'b0;  if1.a = '0;  if1.b = '0;  if1.cin = 1'b0;
        if16.start = 1'b0; if16.a = '0; if16.b = '0; if16.cin = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset busy", 32'(if8.busy), 32'd0);
        chk("reset done", 32'(if8.done), 32'd0);
        chk("reset sum",  32'(if8.sum),  32'd0);
        chk("reset cout", 32'(if8.cout), 32'd0);
        @(posedge clk); #3 rst_n = 1'b1;

        issue8(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0);
        issue8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        issue8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        issue8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
        issue8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

        // A start mid-SHIFT with new operands must be ignored.
        issue8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
        repeat (3) @(negedge clk);
        if8.start = 1'b1; if8.a = 8'hAA;
        @(negedge clk);
        if8.start = 1'b0;

        // start held high: accepted every WIDTH+2 cycles.
        wait_idle8();
        if8.start = 1'b1; if8.a = 8'h01; if8.b = 8'h01; if8.cin = 1'b0;
        base = cyc + 1;
        for (int k = 0; k < 3; k++)
            q8.push_back('{sum: 16'h0002, cout: 1'b0, done_cyc: base + 8 + 10 * k});
        ndone = 0;
        for (int i = 0; i < 60 && ndone < 3; i++) begin
            @(negedge clk);
            if (if8.done) ndone++;
        end
        if8.start = 1'b0;
        chk("held start done count", 32'(ndone), 32'd3);

        // Reset in the middle of an operation aborts it without a done pulse.
        wait_idle8();
        if8.start = 1'b1; if8.a = 8'h5A; if8.b = 8'h33; if8.cin = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(if8.busy), 32'd0);
        chk("abort done", 32'(if8.done), 32'd0);
        chk("abort sum",  32'(if8.sum),  32'd0);
        chk("abort cout", 32'(if8.cout), 32'd0);
        @(negedge clk);
        @(posedge clk); #3 rst_n = 1'b1;
        issue8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1);

        issue1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        issue1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        issue1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        issue1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        issue1(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

        issue16(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
        issue16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        issue16(16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1);
        issue16(16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0);
        issue16(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);

        for (int i = 0; i < 100 && (q8.size() + q1.size() + q16.size()) != 0; i++)
            @(negedge clk);
        chk("w8 drained",  32'(q8.size()),  32'd0);
        chk("w1 drained",  32'(q1.size()),  32'd0);
        chk("w16 drained", 32'(q16.size()), 32'd0);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

`default_nettype wire
